// File: rtl/bwt_req_issue_pkg.sv
// Shared widths and encodings for the BWT memory-request issue stage.
package bwt_req_issue_pkg;

  localparam int READ_NUM_WIDTH_DEF = 6;
  localparam int ADDR_W             = 42;

  // Request kind carried in the low two tag bits; 2'b11 is reserved.
  typedef enum logic [1:0] {
    KIND_K  = 2'b00,
    KIND_L  = 2'b01,
    KIND_KL = 2'b10
  } kind_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_K = 2'd1,
    ISSUE_L = 2'd2
  } state_e;

endpackage

// File: rtl/req_fifo.sv
// Power-of-two request FIFO exposing the head entry and the entry behind it.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         next_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is dropped rather than corrupting the head.
  assign push_ok = push && (count != (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop && (count != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      case ({push_ok, pop_ok})
        2'b10:   count <= count + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   count <= count - {{PTR_W{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign next_data = mem[rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1}];

endmodule

// File: rtl/bwt_req_issue.sv
// Queues k/l occurrence-table lookups and issues them as memory reads, merging k==l.
module bwt_req_issue
  import bwt_req_issue_pkg::*;
#(
  parameter int READ_NUM_WIDTH = READ_NUM_WIDTH_DEF,
  parameter int DEPTH          = 8,
  parameter int SLACK          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [READ_NUM_WIDTH-1:0]   req_read_num,
  input  logic [ADDR_W-1:0]           req_addr_k,
  input  logic [ADDR_W-1:0]           req_addr_l,
  output logic                        stall,
  output logic                        mem_req_valid,
  output logic [ADDR_W-1:0]           mem_req_addr,
  output logic [READ_NUM_WIDTH+1:0]   mem_req_tag,
  input  logic                        mem_req_ready,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic [15:0]                 issued_count
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = READ_NUM_WIDTH + 2 * ADDR_W;

  state_e                    state, state_n;
  kind_e                     kind;
  logic [ENTRY_W-1:0]        head_data, next_data;
  logic [READ_NUM_WIDTH-1:0] head_rn, unused_next_rn;
  logic [ADDR_W-1:0]         head_k, head_l, next_k, next_l;
  logic                      head_merged, next_merged;
  logic                      push, pop;

  assign head_rn        = head_data[ENTRY_W-1 -: READ_NUM_WIDTH];
  assign head_k         = head_data[2*ADDR_W-1 -: ADDR_W];
  assign head_l         = head_data[ADDR_W-1:0];
  assign unused_next_rn = next_data[ENTRY_W-1 -: READ_NUM_WIDTH];
  assign next_k         = next_data[2*ADDR_W-1 -: ADDR_W];
  assign next_l         = next_data[ADDR_W-1:0];
  assign head_merged    = (head_k == head_l);
  assign next_merged    = (next_k == next_l);

  // Back-pressure comes from the registered count so it never depends on req_valid.
  assign stall = (fifo_count >= CNT_W'(DEPTH - SLACK));
  assign push  = req_valid && !stall;
  assign pop   = (state == ISSUE_L) && mem_req_ready;

  req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data ({req_read_num, req_addr_k, req_addr_l}),
    .head_data (head_data),
    .next_data (next_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n       = state;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    kind          = KIND_K;
    mem_req_tag   = '0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) state_n = head_merged ? ISSUE_L : ISSUE_K;
      end
      ISSUE_K: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = head_k;
        mem_req_tag   = {head_rn, KIND_K};
        if (mem_req_ready) state_n = ISSUE_L;
      end
      ISSUE_L: begin
        kind          = head_merged ? KIND_KL : KIND_L;
        mem_req_valid = 1'b1;
        mem_req_addr  = head_merged ? head_k : head_l;
        mem_req_tag   = {head_rn, kind};
        // The entry behind the head decides whether the next issue is merged.
        if (mem_req_ready) begin
          if (fifo_count > CNT_W'(1)) state_n = next_merged ? ISSUE_L : ISSUE_K;
          else                        state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                issued_count <= '0;
    else if (mem_req_valid && mem_req_ready) issued_count <= issued_count + 16'd1;
  end

endmodule

// File: tb/tb_bwt_req_issue.sv
// Directed bench for bwt_req_issue: single, merged, stall, toggled ready, reset, push/pop overlap.
module tb_bwt_req_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [5:0]  req_read_num;
  logic [41:0] req_addr_k;
  logic [41:0] req_addr_l;
  logic        stall;
  logic        mem_req_valid;
  logic [41:0] mem_req_addr;
  logic [7:0]  mem_req_tag;
  logic        mem_req_ready;
  logic [3:0]  fifo_count;
  logic [15:0] issued_count;

  int n_checks = 0;
  int n_pass   = 0;

  bwt_req_issue #(.READ_NUM_WIDTH(6), .DEPTH(8), .SLACK(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_read_num  (req_read_num),
    .req_addr_k    (req_addr_k),
    .req_addr_l    (req_addr_l),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_tag   (mem_req_tag),
    .mem_req_ready (mem_req_ready),
    .fifo_count    (fifo_count),
    .issued_count  (issued_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [5:0] rn, input logic [41:0] k, input logic [41:0] l);
    req_valid    = v;
    req_read_num = rn;
    req_addr_k   = k;
    req_addr_l   = l;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    mem_req_ready = 1'b0;
    set_req(1'b0, '0, '0, '0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Expects an issued request with the given address and tag.
  task automatic expect_req(input string tag, input logic [41:0] addr, input logic [7:0] t);
    check({tag, "_valid"}, mem_req_valid, 1'b1);
    check({tag, "_addr"}, mem_req_addr, addr);
    check({tag, "_tag"}, mem_req_tag, t);
  endtask

  logic [41:0] exp_addr [4];
  logic [7:0]  exp_tag  [4];
  int          idx;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held low.
    rst           = 1'b0;
    mem_req_ready = 1'b0;
    set_req(1'b0, '0, '0, '0);
    tick();
    check("rst_valid", mem_req_valid, 1'b0);
    check("rst_addr", mem_req_addr, 42'h0);
    check("rst_tag", mem_req_tag, 8'h0);
    check("rst_count", fifo_count, 4'd0);
    check("rst_issued", issued_count, 16'd0);
    check("rst_stall", stall, 1'b0);

    // Single k/l request; pushed on the first edge after reset release.
    do_reset();
    mem_req_ready = 1'b1;
    set_req(1'b1, 6'd3, 42'h100, 42'h200);
    tick();
    set_req(1'b0, '0, '0, '0);
    check("single_e0_count", fifo_count, 4'd1);
    check("single_e0_valid", mem_req_valid, 1'b0);
    tick();
    expect_req("single_k", 42'h100, 8'h0C);
    tick();
    expect_req("single_l", 42'h200, 8'h0D);
    tick();
    check("single_done_valid", mem_req_valid, 1'b0);
    check("single_done_count", fifo_count, 4'd0);
    check("single_issued", issued_count, 16'd2);

    // k == l collapses to one merged request.
    do_reset();
    mem_req_ready = 1'b1;
    set_req(1'b1, 6'd1, 42'h55, 42'h55);
    tick();
    set_req(1'b0, '0, '0, '0);
    tick();
    expect_req("merge", 42'h55, 8'h06);
    tick();
    check("merge_done_valid", mem_req_valid, 1'b0);
    check("merge_issued", issued_count, 16'd1);

    // Stall with the memory port blocked: only six of seven requests enter.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 6'(i), 42'h1000 + 42'(i), 42'h2000 + 42'(i));
      tick();
    end
    set_req(1'b1, 6'd6, 42'h1006, 42'h2006);
    check("stall_rise", stall, 1'b1);
    check("stall_count6", fifo_count, 4'd6);
    tick();
    check("stall_held_count", fifo_count, 4'd6);
    expect_req("stall_head_k0", 42'h1000, 8'h00);
    mem_req_ready = 1'b1;
    tick();
    expect_req("stall_l0", 42'h2000, 8'h01);
    check("stall_still_count", fifo_count, 4'd6);
    tick();
    check("stall_pop_count", fifo_count, 4'd5);
    check("stall_drop", stall, 1'b0);
    expect_req("stall_k1", 42'h1001, 8'h04);
    tick();
    set_req(1'b0, '0, '0, '0);
    check("stall_push7_count", fifo_count, 4'd6);
    check("stall_rise2", stall, 1'b1);
    expect_req("stall_l1", 42'h2001, 8'h05);
    tick();
    for (int i = 2; i < 7; i++) begin
      expect_req($sformatf("drain_k%0d", i), 42'h1000 + 42'(i), {6'(i), 2'b00});
      tick();
      expect_req($sformatf("drain_l%0d", i), 42'h2000 + 42'(i), {6'(i), 2'b01});
      tick();
    end
    check("drain_valid", mem_req_valid, 1'b0);
    check("drain_count", fifo_count, 4'd0);
    check("drain_issued", issued_count, 16'd14);

    // Ready toggling: outputs hold while blocked, order k0,l0,k1,l1.
    do_reset();
    set_req(1'b1, 6'd2, 42'h300, 42'h301);
    tick();
    set_req(1'b1, 6'd5, 42'h310, 42'h311);
    tick();
    set_req(1'b0, '0, '0, '0);
    exp_addr[0] = 42'h300; exp_tag[0] = 8'h08;
    exp_addr[1] = 42'h301; exp_tag[1] = 8'h09;
    exp_addr[2] = 42'h310; exp_tag[2] = 8'h14;
    exp_addr[3] = 42'h311; exp_tag[3] = 8'h15;
    idx = 0;
    expect_req("tog_start", exp_addr[0], exp_tag[0]);
    for (int c = 0; c < 8; c++) begin
      mem_req_ready = c[0];
      tick();
      if (c[0]) idx++;
      if (idx < 4) expect_req($sformatf("tog_c%0d", c), exp_addr[idx], exp_tag[idx]);
      else         check($sformatf("tog_c%0d_valid", c), mem_req_valid, 1'b0);
    end
    check("tog_issued", issued_count, 16'd4);

    // Reset while in ISSUE_L with three queued entries.
    mem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 6'(i), 42'h400 + 42'(i), 42'h500 + 42'(i));
      tick();
    end
    set_req(1'b0, '0, '0, '0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    expect_req("midrst_l0", 42'h500, 8'h01);
    check("midrst_pre_count", fifo_count, 4'd3);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", mem_req_valid, 1'b0);
    check("midrst_count", fifo_count, 4'd0);
    check("midrst_issued", issued_count, 16'd0);
    tick();
    rst           = 1'b1;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("post_rst_idle%0d", c), mem_req_valid, 1'b0);
    end
    check("post_rst_count", fifo_count, 4'd0);

    // Simultaneous push/pop, then a merged entry issued straight from ISSUE_L.
    do_reset();
    mem_req_ready = 1'b1;
    set_req(1'b1, 6'd9, 42'h1, 42'h2);
    tick();
    set_req(1'b1, 6'd7, 42'h77, 42'h77);
    tick();
    set_req(1'b0, '0, '0, '0);
    expect_req("pp_kx", 42'h1, 8'h24);
    tick();
    set_req(1'b1, 6'd4, 42'h90, 42'h91);
    expect_req("pp_lx", 42'h2, 8'h25);
    check("pp_pre_count", fifo_count, 4'd2);
    tick();
    set_req(1'b0, '0, '0, '0);
    check("pp_count_same", fifo_count, 4'd2);
    expect_req("pp_merge", 42'h77, 8'h1E);
    tick();
    expect_req("pp_kw", 42'h90, 8'h10);
    check("pp_count1", fifo_count, 4'd1);
    tick();
    expect_req("pp_lw", 42'h91, 8'h11);
    tick();
    check("pp_done_valid", mem_req_valid, 1'b0);
    check("pp_issued", issued_count, 16'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bwt_req_issue.md
BWT_REQ_ISSUE -- requirements
Module: bwt_req_issue

Interface
REQ-001 Parameter READ_NUM_WIDTH, default `READ_NUM_WIDTH, read-number field width.
REQ-002 Parameter DEPTH, default 8, request FIFO entries (power of two).
REQ-003 Parameter SLACK, default 2, free entries kept for in-flight upstream requests.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  upstream request_valid from control stage.
REQ-007 req_read_num  input  READ_NUM_WIDTH  read number of request.
REQ-008 req_addr_k, req_addr_l  input  42 each  occurrence-table addresses for k and l.
REQ-009 stall  output  1  back-pressure to all control pipeline stages.
REQ-010 mem_req_valid  output  1  memory read request valid.
REQ-011 mem_req_addr  output  42  memory read address.
REQ-012 mem_req_tag  output  READ_NUM_WIDTH+2  {read_num, kind[1:0]}.
REQ-013 mem_req_ready  input  1  memory port accepts request this cycle.
REQ-014 fifo_count  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-015 issued_count  output  16  memory requests accepted since reset, wraps at 65535->0.

Function
REQ-016 stall SHALL equal (fifo_count >= DEPTH-SLACK), decoded from registered count only.
REQ-017 Push SHALL occur when req_valid=1 and stall=0; held requests during stall SHALL NOT be pushed.
REQ-018 FIFO entry SHALL be {read_num, addr_k, addr_l}; pointers wrap modulo DEPTH.
REQ-019 Overflow is impossible by REQ-016/017; a push when count=DEPTH SHALL be dropped (assertion in bench).
REQ-020 FSM states: IDLE, ISSUE_K, ISSUE_L.
REQ-021 IDLE: if count!=0 at edge, next state ISSUE_K (or ISSUE_L-merged per REQ-024), mem_req_valid=1 registered.
REQ-022 ISSUE_K: addr=head addr_k, kind=2'b00; on mem_req_ready -> ISSUE_L.
REQ-023 ISSUE_L: addr=head addr_l, kind=2'b01; on mem_req_ready pop head; next ISSUE_K for new head if count after pop !=0, else IDLE with valid=0.
REQ-024 Merge: if head addr_k==addr_l, single request in ISSUE_L with kind=2'b10, addr=addr_k; pop on ready.
REQ-025 mem_req_valid, addr, tag SHALL be stable while valid=1 and ready=0.
REQ-026 Latency: req sampled at edge E0 -> mem_req_valid high after edge E1 from IDLE.
REQ-027 Back-to-back: ready held high yields one accepted request per cycle, no idle cycle between entries.
REQ-028 Simultaneous push and pop: count unchanged, both applied.
REQ-029 issued_count SHALL increment on every cycle with mem_req_valid&&mem_req_ready.
REQ-030 kind=2'b11 reserved, never generated.

Reset
REQ-031 rst low SHALL immediately clear: state=IDLE, pointers, fifo_count=0, issued_count=0, mem_req_valid=0, mem_req_addr=0, mem_req_tag=0, stall=0.
REQ-032 Reset mid-transaction SHALL drop queued and pending requests; no request re-issued after release.
REQ-033 First push possible on first rising edge after rst deasserts.

Structure
REQ-034 READ_NUM_WIDTH, 42-bit address width and kind encodings SHALL reside in pipeline_head.vh.
REQ-035 FIFO SHALL be sub-module req_fifo (push, pop, head data, count); FSM and counter in top.

Verification
REQ-036 Single request k=0x100,l=0x200,rn=3, ready=1 -> valid after E1: addr 0x100 tag{3,00}, next cycle 0x200 tag{3,01}, then valid=0, issued_count=2.
REQ-037 k=l=0x55,rn=1 -> exactly one request addr 0x55 tag{1,10}, issued_count=1.
REQ-038 ready=0, 7 consecutive req_valid -> stall rises when count=6; only 6 pushed; upstream holding 7th pushed after ready returns and count drops.
REQ-039 ready toggles 1/0 per cycle -> addr/tag stable across ready=0 cycles; request order k0,l0,k1,l1 preserved.
REQ-040 rst low during ISSUE_L with 3 queued -> valid=0 same cycle, count=0; after release no requests issued until new req_valid.
